// File: rtl/snake_pkg.sv
// Shared types and constants for the snake-game food position generator.
// lfsr_taps() returns maximal-length Galois tap masks for 8..32-bit LFSRs.
package snake_pkg;

  localparam int X_W_DEF = 8;
  localparam int Y_W_DEF = 7;

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    CHECK,
    RESP,
    SCAN_CHECK,
    SCAN_RESP,
    DONE
  } fsm_state_e;

  // Mask bit (t-1) is set for each feedback tap t of a primitive polynomial.
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] taps;
    case (width)
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_B400;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0004_0023;
      20:      taps = 32'h0009_0000;
      21:      taps = 32'h0014_0000;
      22:      taps = 32'h0030_0000;
      23:      taps = 32'h0042_0000;
      24:      taps = 32'h00E1_0000;
      25:      taps = 32'h0120_0000;
      26:      taps = 32'h0200_0023;
      27:      taps = 32'h0400_0013;
      28:      taps = 32'h0900_0000;
      29:      taps = 32'h1400_0000;
      30:      taps = 32'h2000_0029;
      31:      taps = 32'h4800_0000;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_0000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/food_pos_gen_if.sv
// Request/response and occupancy-query signals of the food position generator.
// master = game logic side, slave = generator.
interface food_pos_gen_if #(
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int LFSR_W = 16
);
  logic              seed_load;
  logic [LFSR_W-1:0] seed;
  logic              req;
  logic              busy;
  logic              valid;
  logic [X_W-1:0]    pos_x;
  logic [Y_W-1:0]    pos_y;
  logic              full;
  logic              chk_valid;
  logic [X_W-1:0]    chk_x;
  logic [Y_W-1:0]    chk_y;
  logic              chk_occupied;

  modport master (
    output seed_load, seed, req, chk_occupied,
    input  busy, valid, pos_x, pos_y, full, chk_valid, chk_x, chk_y
  );

  modport slave (
    input  seed_load, seed, req, chk_occupied,
    output busy, valid, pos_x, pos_y, full, chk_valid, chk_x, chk_y
  );
endinterface

// File: rtl/lfsr_gen.sv
// Free-running right-shifting Galois LFSR with a synchronous load; a zero
// load value would lock the register up, so it is replaced by SEED.
module lfsr_gen
  import snake_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state
);
  localparam logic [31:0]      TAPS_ALL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] step;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_step
    if (gi == WIDTH - 1) begin : g_top
      assign step[gi] = TAPS[gi] & state_q[0];
    end else begin : g_mid
      assign step[gi] = state_q[gi+1] ^ (TAPS[gi] & state_q[0]);
    end
  end

  always_comb begin
    state_d = step;
    if (load) begin
      state_d = (load_val == '0) ? SEED : load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;
endmodule

// File: rtl/food_pos_gen.sv
// Food position generator: random in-window draws checked against the snake body,
// falling back to a raster scan of the window after MAX_TRIES failed draws.
module food_pos_gen
  import snake_pkg::*;
#(
  parameter int                X_W       = X_W_DEF,
  parameter int                Y_W       = Y_W_DEF,
  parameter int                X_MIN     = 15,
  parameter int                X_MAX     = 130,
  parameter int                Y_MIN     = 15,
  parameter int                Y_MAX     = 100,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                MAX_TRIES = 16
) (
  input logic           clk,
  input logic           rst,
  food_pos_gen_if.slave bus
);
  localparam int             TW      = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0]  TRIES_C = MAX_TRIES[TW-1:0];
  localparam logic [X_W-1:0] XMIN_C  = X_MIN[X_W-1:0];
  localparam logic [X_W-1:0] XMAX_C  = X_MAX[X_W-1:0];
  localparam logic [Y_W-1:0] YMIN_C  = Y_MIN[Y_W-1:0];
  localparam logic [Y_W-1:0] YMAX_C  = Y_MAX[Y_W-1:0];

  fsm_state_e       state_q, state_d;
  logic [TW-1:0]    tries_q, tries_d, tries_inc;
  logic [X_W-1:0]   chk_x_q, chk_x_d, pos_x_q, pos_x_d;
  logic [Y_W-1:0]   chk_y_q, chk_y_d, pos_y_q, pos_y_d;
  logic             full_q, full_d;
  logic [LFSR_W-1:0] lfsr_state;
  logic [X_W-1:0]   raw_x;
  logic [Y_W-1:0]   raw_y;
  logic             in_win;
  logic             unused_lfsr_bits;

  lfsr_gen #(
    .WIDTH (LFSR_W),
    .SEED  (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (bus.seed_load),
    .load_val (bus.seed),
    .state    (lfsr_state)
  );

  // Candidate comes from the two ends of the LFSR; the bits between only feed the sequence.
  assign raw_x            = lfsr_state[X_W-1:0];
  assign raw_y            = lfsr_state[LFSR_W-1 -: Y_W];
  assign unused_lfsr_bits = ^lfsr_state;
  assign in_win = (raw_x >= XMIN_C) && (raw_x <= XMAX_C) &&
                  (raw_y >= YMIN_C) && (raw_y <= YMAX_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tries_q <= '0;
      chk_x_q <= XMIN_C;
      chk_y_q <= YMIN_C;
      pos_x_q <= XMIN_C;
      pos_y_q <= YMIN_C;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      chk_x_q <= chk_x_d;
      chk_y_q <= chk_y_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      full_q  <= full_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    tries_inc = tries_q + 1'b1;
    chk_x_d   = chk_x_q;
    chk_y_d   = chk_y_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    full_d    = full_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d = DRAW;
          tries_d = '0;
        end
      end
      DRAW: begin
        tries_d = tries_inc;
        if (in_win) begin
          state_d = CHECK;
          chk_x_d = raw_x;
          chk_y_d = raw_y;
        end else if (tries_inc >= TRIES_C) begin
          state_d = SCAN_CHECK;
          chk_x_d = XMIN_C;
          chk_y_d = YMIN_C;
        end
      end
      CHECK: state_d = RESP;
      RESP: begin
        if (!bus.chk_occupied) begin
          state_d = DONE;
          pos_x_d = chk_x_q;
          pos_y_d = chk_y_q;
          full_d  = 1'b0;
        end else if (tries_q < TRIES_C) begin
          state_d = DRAW;
        end else begin
          state_d = SCAN_CHECK;
          chk_x_d = XMIN_C;
          chk_y_d = YMIN_C;
        end
      end
      SCAN_CHECK: state_d = SCAN_RESP;
      SCAN_RESP: begin
        if (!bus.chk_occupied) begin
          state_d = DONE;
          pos_x_d = chk_x_q;
          pos_y_d = chk_y_q;
          full_d  = 1'b0;
        end else if ((chk_x_q == XMAX_C) && (chk_y_q == YMAX_C)) begin
          state_d = DONE;
          pos_x_d = XMIN_C;
          pos_y_d = YMIN_C;
          full_d  = 1'b1;
        end else if (chk_x_q == XMAX_C) begin
          state_d = SCAN_CHECK;
          chk_x_d = XMIN_C;
          chk_y_d = chk_y_q + 1'b1;
        end else begin
          state_d = SCAN_CHECK;
          chk_x_d = chk_x_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.valid     = (state_q == DONE);
    bus.chk_valid = (state_q == CHECK) || (state_q == SCAN_CHECK);
  end

  assign bus.pos_x = pos_x_q;
  assign bus.pos_y = pos_y_q;
  assign bus.full  = full_q;
  assign bus.chk_x = chk_x_q;
  assign bus.chk_y = chk_y_q;
endmodule

// File: tb/tb_food_pos_gen.sv
// Randomised bench for food_pos_gen: a draw-by-draw reference model predicts
// each position, full flag, latency and query count from the LFSR sequence.
module tb_food_pos_gen;
  localparam int N_CELLS = 116 * 86;

  logic clk;
  logic rst;

  food_pos_gen_if #(.X_W(8), .Y_W(7), .LFSR_W(16)) bus ();

  food_pos_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  nchecks = 0;
  int  nerrs   = 0;
  bit  occ [0:255][0:127];

  // observations published by the compare process
  int  vcount = 0;
  int  last_lat, last_x, last_y, last_full, last_nq;
  bit  last_scan;

  task automatic check(input string name, input longint got, input longint exp);
    nchecks++;
    if (got != exp) begin
      nerrs++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [15:0] m_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic bit in_window(input int x, input int y);
    return (x >= 15) && (x <= 130) && (y >= 15) && (y <= 100);
  endfunction

  // l1 = LFSR value in the first DRAW cycle; lat is counted from the req cycle.
  function automatic void predict(input logic [15:0] l1, output int px, output int py,
                                  output bit pf, output int lat, output int nq,
                                  output bit scanned);
    logic [15:0] l;
    int t, tries, rx, ry, sc;
    l = l1; t = 1; tries = 0; nq = 0; scanned = 0; sc = 0;
    px = 15; py = 15; pf = 0; lat = 0;
    while (1) begin
      rx = int'(l[7:0]);
      ry = int'(l[15:9]);
      tries++;
      if (in_window(rx, ry)) begin
        nq++;
        if (!occ[rx][ry]) begin
          px = rx; py = ry; lat = t + 3;
          return;
        end
        if (tries >= 16) begin sc = t + 3; break; end
        t += 3;
        l = m_step(m_step(m_step(l)));
      end else begin
        if (tries >= 16) begin sc = t + 1; break; end
        t += 1;
        l = m_step(l);
      end
    end
    scanned = 1;
    for (int i = 0; i < N_CELLS; i++) begin
      rx = 15 + i % 116;
      ry = 15 + i / 116;
      nq++;
      if (!occ[rx][ry]) begin
        px = rx; py = ry; lat = sc + 2 * i + 2;
        return;
      end
    end
    px = 15; py = 15; pf = 1; lat = sc + 2 * N_CELLS;
  endfunction

  // Occupancy responder: answer lands in the cycle after the strobe, noise otherwise.
  initial begin
    bit pend_v, pend_o;
    pend_v = 0; pend_o = 0;
    bus.chk_occupied = 1'b0;
    forever begin
      @(negedge clk);
      bus.chk_occupied = pend_v ? pend_o : 1'($urandom_range(0, 1));
      pend_v = bus.chk_valid;
      pend_o = occ[bus.chk_x][bus.chk_y];
    end
  end

  // Compare process: model LFSR and outstanding request, checked every cycle.
  initial begin
    int cyc, acc, done, q_cnt;
    int e_px, e_py, e_lat, e_nq;
    bit e_pf, e_scan, act, exp_busy, exp_valid;
    logic [15:0] m_lfsr, m_next;
    cyc = 0; acc = 0; done = 0; q_cnt = 0; act = 0;
    m_lfsr = 16'hACE1;
    forever begin
      @(negedge clk);
      if (rst) begin
        act    = 0;
        m_next = 16'hACE1;
      end else begin
        exp_busy  = act && (cyc > acc) && (cyc <= done);
        exp_valid = act && (cyc == done);
        check("busy", bus.busy, exp_busy);
        check("valid", bus.valid, exp_valid);
        if (!exp_busy) check("chk_valid_idle", bus.chk_valid, 0);
        if (bus.chk_valid) begin
          q_cnt++;
          check("query_in_window", in_window(int'(bus.chk_x), int'(bus.chk_y)), 1);
        end
        if (bus.valid) begin
          vcount++;
          last_lat  = cyc - acc;
          last_x    = int'(bus.pos_x);
          last_y    = int'(bus.pos_y);
          last_full = int'(bus.full);
          last_nq   = q_cnt;
        end
        if (exp_valid) begin
          check("pos_x", bus.pos_x, e_px);
          check("pos_y", bus.pos_y, e_py);
          check("full", bus.full, e_pf);
          check("query_count", q_cnt, e_nq);
        end
        m_next = bus.seed_load ? ((bus.seed == 16'h0) ? 16'hACE1 : bus.seed) : m_step(m_lfsr);
        if (bus.req && !(act && cyc <= done)) begin
          predict(m_next, e_px, e_py, e_pf, e_lat, e_nq, e_scan);
          act = 1; acc = cyc; done = cyc + e_lat; q_cnt = 0;
          last_scan = e_scan;
        end
      end
      m_lfsr = m_next;
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
  endtask

  task automatic fill_occ(input int mode, input int pct);
    for (int x = 0; x < 256; x++)
      for (int y = 0; y < 128; y++)
        case (mode)
          0:       occ[x][y] = 1'b0;
          1:       occ[x][y] = !((x == 20) && (y == 15));
          2:       occ[x][y] = 1'b1;
          default: occ[x][y] = ($urandom_range(0, 99) < pct);
        endcase
  endtask

  // Pulses req this cycle and waits for a valid; noisy adds reqs while busy and on the valid cycle.
  task automatic do_req(input int budget, input bit noisy);
    int start;
    bit got;
    start = vcount;
    got = 0;
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    bus.seed_load = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      bus.req = 1'b0;
      if (vcount > start) got = 1;
      else if (noisy) bus.req = bus.valid || ($urandom_range(0, 3) == 0);
    end
    bus.req = 1'b0;
    check("valid_within_budget", got, 1);
    if (got) check("one_valid_per_request", vcount - start, 1);
  endtask

  initial begin
    int rx [0:2][0:4];
    int ry [0:2][0:4];
    int diff, start;
    bit found;
    logic [15:0] seeds [0:2];
    rst = 1'b1;
    bus.req = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed = 16'h0;
    fill_occ(0, 0);
    do_reset(4);

    // reset state
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_full", bus.full, 0);
    check("rst_chk_valid", bus.chk_valid, 0);
    check("rst_pos_x", bus.pos_x, 15);
    check("rst_pos_y", bus.pos_y, 15);
    check("rst_chk_x", bus.chk_x, 15);
    check("rst_chk_y", bus.chk_y, 15);
    check("rst_lfsr", dut.u_lfsr.state, 16'hACE1);

    // free board, 100 requests
    for (int r = 0; r < 100; r++) begin
      for (int g = $urandom_range(0, 5); g > 0; g--) tick();
      do_req(200, 0);
      check("free_pos_x_range", (last_x >= 15) && (last_x <= 130), 1);
      check("free_pos_y_range", (last_y >= 15) && (last_y <= 100), 1);
      check("free_full", last_full, 0);
      check("free_latency_min", last_lat >= 4, 1);
      if (!last_scan) check("free_latency_max", last_lat <= 16 * 3 + 4, 1);
    end

    // single free cell at (20,15)
    fill_occ(1, 0);
    for (int r = 0; r < 3; r++) begin
      tick();
      do_req(400, 0);
      check("one_free_pos_x", last_x, 20);
      check("one_free_pos_y", last_y, 15);
      check("one_free_full", last_full, 0);
      check("one_free_queries_bound", last_nq <= 16 + 6, 1);
    end

    // full board
    fill_occ(2, 0);
    tick();
    do_req(25000, 0);
    check("full_flag", last_full, 1);
    check("full_pos_x", last_x, 15);
    check("full_pos_y", last_y, 15);
    check("full_scan_queries", (last_nq >= N_CELLS) && (last_nq <= N_CELLS + 16), 1);

    // seed loading
    fill_occ(0, 0);
    tick();
    bus.seed_load = 1'b1; bus.seed = 16'h0;
    tick();
    bus.seed_load = 1'b0;
    check("lfsr_zero_seed", dut.u_lfsr.state, 16'hACE1);
    tick();
    check("lfsr_step_after_seed", dut.u_lfsr.state, 16'hE270);
    bus.seed_load = 1'b1; bus.seed = 16'h1234;
    tick();
    bus.seed_load = 1'b0;
    check("lfsr_nonzero_seed", dut.u_lfsr.state, 16'h1234);

    seeds[0] = 16'h1234; seeds[1] = 16'h1234; seeds[2] = 16'h4321;
    for (int s = 0; s < 3; s++) begin
      do_reset(2);
      bus.seed_load = 1'b1; bus.seed = seeds[s];
      tick();
      bus.seed_load = 1'b0;
      for (int r = 0; r < 5; r++) begin
        for (int g = 0; g < r; g++) tick();
        do_req(200, 0);
        rx[s][r] = last_x;
        ry[s][r] = last_y;
      end
    end
    diff = 0;
    for (int r = 0; r < 5; r++) begin
      check("repeat_pos_x", rx[1][r], rx[0][r]);
      check("repeat_pos_y", ry[1][r], ry[0][r]);
      if ((rx[2][r] != rx[0][r]) || (ry[2][r] != ry[0][r])) diff++;
    end
    check("other_seed_differs", diff > 0, 1);

    // reset during RESP
    fill_occ(3, 50);
    tick();
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (bus.chk_valid) found = 1;
      else tick();
    end
    check("rst_test_query_seen", found, 1);
    start = vcount;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_chk_valid", bus.chk_valid, 0);
    check("abort_busy", bus.busy, 0);
    for (int i = 0; i < 10; i++) tick();
    check("abort_no_valid", vcount - start, 0);
    do_req(400, 0);

    // reqs while busy and on the valid cycle, random occupancy and seeds
    for (int r = 0; r < 60; r++) begin
      if (r % 10 == 0) fill_occ(3, $urandom_range(30, 95));
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        bus.seed_load = ($urandom_range(0, 3) == 0);
        bus.seed = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
        tick();
      end
      bus.seed_load = ($urandom_range(0, 3) == 0);
      bus.seed = 16'($urandom);
      do_req(25000, 1);
      for (int i = 0; i < 3; i++) tick();
      check("settled_idle", bus.busy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
